// File: rtl/pkg_keccak.sv
// Keccak shared types: 64-bit lanes, 5x5 state indexed [y][x].
package pkg_keccak;

    localparam int unsigned N = 64;

    typedef logic [N-1:0] k_lane;
    typedef k_lane [4:0]  k_plane;
    typedef k_plane [4:0] k_state;

endpackage

// File: rtl/keccak_squeeze_out_if.sv
// State-capture and lane-stream handshake bundle for keccak_squeeze_out.
interface keccak_squeeze_out_if #(
    parameter int unsigned N = pkg_keccak::N
);
    pkg_keccak::k_state state_i;
    logic               state_valid_i;
    logic               state_ready_o;
    logic [N-1:0]       dout_o;
    logic               dout_valid_o;
    logic               dout_ready_i;
    logic               dout_last_o;

    // Serializer side
    modport slave (
        input  state_i, state_valid_i, dout_ready_i,
        output state_ready_o, dout_o, dout_valid_o, dout_last_o
    );

    // Permutation core / digest consumer side
    modport master (
        output state_i, state_valid_i, dout_ready_i,
        input  state_ready_o, dout_o, dout_valid_o, dout_last_o
    );
endinterface

// File: rtl/keccak_squeeze_out.sv
// Keccak output lane serializer: captures a full state in one cycle and
// streams lanes 0..NUM_OUT_LANES-1 (plane-major) over valid/ready.
// Optional feature macro: KECCAK_SQUEEZE_BYTESWAP_EN (byte-reverse each lane
// at capture for big-endian digest byte order).
module keccak_squeeze_out #(
    parameter int unsigned NUM_OUT_LANES = 4,
    parameter int unsigned N             = pkg_keccak::N
) (
    input  logic                 clk,
    input  logic                 rst_n,
    keccak_squeeze_out_if.slave  bus
);

    localparam int unsigned CW = $clog2(NUM_OUT_LANES) + 1;
    localparam int unsigned IW = (NUM_OUT_LANES > 1) ? $clog2(NUM_OUT_LANES) : 1;
    localparam int unsigned NB = N / 8;

    // Elaboration-time legality checks
    if ((NUM_OUT_LANES < 1) || (NUM_OUT_LANES > 25)) begin : g_bad_lanes
        $error("keccak_squeeze_out: NUM_OUT_LANES must be 1..25");
    end
`ifdef KECCAK_SQUEEZE_BYTESWAP_EN
    if ((N % 8) != 0) begin : g_bad_width
        $error("keccak_squeeze_out: byteswap requires N to be a multiple of 8");
    end
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_shadow [NUM_OUT_LANES];
    logic [N-1:0]  r_dout;
    logic          r_dout_valid;
    logic          r_dout_last;
    logic          r_state_ready;

    logic [N-1:0]  w_lane [NUM_OUT_LANES];
    logic [CW-1:0] w_next;
    logic [IW-1:0] w_next_idx;
    logic          w_unused_state;

    // Byte reversal of one lane (only referenced when the swap is enabled)
    function automatic logic [N-1:0] f_swap(input logic [N-1:0] v);
        logic [N-1:0] r;
        r = '0;
        for (int b = 0; b < int'(NB); b++) begin
            r[8*b +: 8] = v[8*(int'(NB)-1-b) +: 8];
        end
        return r;
    endfunction

    // Lane selection: lane i = state[i/5][i%5], optionally byte-reversed
    for (genvar gi = 0; gi < int'(NUM_OUT_LANES); gi++) begin : g_lane
        logic [N-1:0] w_raw;
        assign w_raw = N'(bus.state_i[3'(gi / 5)][3'(gi % 5)]);
`ifdef KECCAK_SQUEEZE_BYTESWAP_EN
        assign w_lane[gi] = f_swap(w_raw);
`else
        assign w_lane[gi] = w_raw;
`endif
    end

    // Lanes beyond the digest are intentionally dropped
    assign w_unused_state = ^bus.state_i;

    assign w_next     = r_cnt + CW'(1);
    assign w_next_idx = IW'(w_next);

    // Capture/stream FSM with registered handshake and data outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_dout        <= '0;
            r_dout_valid  <= 1'b0;
            r_dout_last   <= 1'b0;
            r_state_ready <= 1'b1;
            for (int i = 0; i < int'(NUM_OUT_LANES); i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.state_valid_i) begin
                        for (int i = 0; i < int'(NUM_OUT_LANES); i++) begin
                            r_shadow[i] <= w_lane[i];
                        end
                        r_cnt         <= '0;
                        r_dout        <= w_lane[0];
                        r_dout_valid  <= 1'b1;
                        r_dout_last   <= (NUM_OUT_LANES == 1);
                        r_state_ready <= 1'b0;
                        r_state       <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (bus.dout_ready_i) begin
                        if (r_dout_last) begin
                            r_cnt         <= '0;
                            r_dout        <= '0;
                            r_dout_valid  <= 1'b0;
                            r_dout_last   <= 1'b0;
                            r_state_ready <= 1'b1;
                            r_state       <= ST_IDLE;
                        end else begin
                            r_cnt       <= w_next;
                            r_dout      <= r_shadow[w_next_idx];
                            r_dout_last <= (w_next == CW'(NUM_OUT_LANES - 1));
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.state_ready_o = r_state_ready;
    assign bus.dout_o        = r_dout;
    assign bus.dout_valid_o  = r_dout_valid;
    assign bus.dout_last_o   = r_dout_last;

endmodule

// File: doc/keccak_squeeze_out.md
# keccak_squeeze_out

Output-side lane serializer for the Keccak core. It captures a completed permutation state of type `pkg_keccak::k_state` in a single cycle. It then streams the first `NUM_OUT_LANES` lanes, one `N`-bit lane per beat, over a valid/ready word interface. It is the read-out counterpart of the absorb input buffer and sits between the permutation core and the digest consumer.

## Interface
Parameters:
- `NUM_OUT_LANES`, default 4: lanes emitted per captured state (4 gives a 256-bit digest). Legal range 1..25; elaboration fails outside it.
- `N`, default `pkg_keccak::N` (64): lane width in bits.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `state_i`  in  `k_state` (1600 bits)  completed permutation state.
- `state_valid_i`  in  1  `state_i` is valid.
- `state_ready_o`  out  1  block can capture a state.
- `dout_o`  out  N  current output lane.
- `dout_valid_o`  out  1  `dout_o` is valid.
- `dout_ready_i`  in  1  consumer accepts `dout_o`.
- `dout_last_o`  out  1  current beat is the final lane of the digest.

## Operation
- FSM states: IDLE and SEND.
- IDLE:
  - `state_ready_o`=1 and `dout_valid_o`=0.
  - Capture occurs when `state_valid_i && state_ready_o` at a rising edge.
  - On capture, lanes 0..`NUM_OUT_LANES`-1 are copied into a shadow register, the beat counter is cleared to 0, and the FSM goes to SEND.
- Lane ordering: lane index i maps to `state_i[y][x]` with y = i / 5 and x = i % 5 (plane-major, sheet-minor).
- SEND:
  - `state_ready_o`=0 and `dout_valid_o`=1.
  - `dout_o` = shadow[cnt].
  - `dout_last_o` = (cnt == `NUM_OUT_LANES`-1).
- Accepted beat (`dout_valid_o && dout_ready_i`):
  - Not the last beat: cnt increments.
  - Last beat: FSM returns to IDLE and cnt resets to 0.
- Counter width is $clog2(`NUM_OUT_LANES`)+1 bits. It never wraps because it is cleared on the last beat.
- `state_i` is sampled only on the capture edge. Changes on `state_i` during SEND have no effect.
- `state_valid_i` asserted during SEND is ignored. The source must hold it until `state_ready_o`.
- Valid/ready rules:
  - While `dout_valid_o`=1 and `dout_ready_i`=0, `dout_o` and `dout_last_o` stay stable.
  - `dout_valid_o` never drops without acceptance.
- `NUM_OUT_LANES`=1: a single beat, with `dout_last_o`=1 on it.

## Timing
- Reset values (async, on `rst_n`=0):
  - FSM = IDLE, cnt = 0, shadow = 0.
  - `state_ready_o`=1 after reset is released.
  - `dout_valid_o`=0, `dout_last_o`=0, `dout_o`=0.
- Outputs are driven from registers and FSM state only. There is no combinational path from `dout_ready_i` or `state_valid_i` to any output.
- Latency: capture at edge k puts the first lane on `dout_o` with `dout_valid_o`=1 in the cycle after edge k.
- With `dout_ready_i` held at 1:
  - The digest takes `NUM_OUT_LANES` cycles.
  - `state_ready_o` returns to 1 in the cycle after the last beat is accepted.
  - One bubble cycle exists between digests; the minimum period is `NUM_OUT_LANES`+1 cycles.
- Reset mid-SEND: within the same cycle the outputs drop to reset values and the partial digest is discarded. No beats are emitted after reset is released until a new capture.

## Configuration
- Macro: `KECCAK_SQUEEZE_BYTESWAP_EN`.
- Defined: each emitted lane is byte-reversed (byte 0 ↔ byte N/8-1), giving big-endian digest byte order on the bus. The swap is applied at capture, so latency is unchanged. Requires N % 8 == 0.
- Undefined: lanes are emitted exactly as stored in `state_i`.

## Test plan
- Basic digest:
  - Stimulus: after reset, capture a state where lane(x,y) = 5y+x, with `dout_ready_i`=1 and the macro undefined.
  - Required response: beats 0x0,0x1,0x2,0x3 on 4 consecutive cycles, `dout_last_o` only on 0x3, and `state_ready_o`=1 one cycle later.
- Backpressure:
  - Stimulus: drive `dout_ready_i`=0 for 3 cycles during beat 1.
  - Required response: `dout_o` holds 0x1 and `dout_valid_o` stays 1; the sequence resumes with 0x2 and no beat is lost or duplicated.
- Input isolation:
  - Stimulus: during SEND, change `state_i` to all-ones and assert `state_valid_i`.
  - Required response: the emitted beats are unchanged, and the second state is captured only after the last beat with `state_ready_o`=1.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 after beat 1 is accepted.
  - Required response: `dout_valid_o`=0 immediately. After release, the next captured state emits from lane 0.
- Byteswap:
  - Stimulus: define `KECCAK_SQUEEZE_BYTESWAP_EN` and set lane 1 = 0x0000000000000001.
  - Required response: beat 1 = 0x0100000000000000.
- Parameter sweep:
  - Stimulus: `NUM_OUT_LANES`=1 and 25 with the lane pattern 5y+x.
  - Required response: one beat 0x0 with last=1; 25 beats 0x0..0x18 with last on 0x18.
